exam_job_scheduler: RTL and testbench

Sequences the exam compute core (ports clk, rst, a, b, c, d, g, h, start, done). Queues up to DEPTH operand sets from a requester and issues them to the core one at a time. The core can only return to idle through its own reset, so this block pulses the core's reset between jobs. It returns g/h per job with a tag and applies a watchdog timeout. It sits between the switch/key front-end FSM and the core, in place of the single-shot start wiring.

---
 rtl/exam_job_scheduler_pkg.sv | 23 ++
 rtl/exam_job_scheduler_if.sv | 34 +++
 rtl/exam_job_fifo.sv | 46 ++++
 rtl/exam_job_scheduler.sv | 155 +++++++++++++++
 tb/tb_exam_job_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exam_job_scheduler_pkg.sv
// Shared types and constants for the exam core job scheduler.
package exam_sched_pkg;

  localparam int OPW = 16;
  localparam logic [OPW-1:0] TIMEOUT_VALUE = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    ARM     = 3'd2,
    RUN     = 3'd3,
    CAPTURE = 3'd4,
    ABORT   = 3'd5
  } state_t;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic [OPW-1:0] c;
    logic [OPW-1:0] d;
  } job_t;

endpackage

// File: rtl/exam_job_scheduler_if.sv
// Requester-side bundle: job offer/accept, queue depth, result return and busy.
interface exam_job_scheduler_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  import exam_sched_pkg::*;

  localparam int PEND_W = $clog2(DEPTH) + 1;

  logic              job_valid;
  logic              job_ready;
  logic [OPW-1:0]    job_a;
  logic [OPW-1:0]    job_b;
  logic [OPW-1:0]    job_c;
  logic [OPW-1:0]    job_d;
  logic [PEND_W-1:0] pending;
  logic              res_valid;
  logic [OPW-1:0]    res_g;
  logic [OPW-1:0]    res_h;
  logic              res_timeout;
  logic [TAG_W-1:0]  res_tag;
  logic              busy;

  modport master (
    output job_valid, job_a, job_b, job_c, job_d,
    input  job_ready, pending, res_valid, res_g, res_h, res_timeout, res_tag, busy
  );

  modport slave (
    input  job_valid, job_a, job_b, job_c, job_d,
    output job_ready, pending, res_valid, res_g, res_h, res_timeout, res_tag, busy
  );

endinterface

// File: rtl/exam_job_fifo.sv
// DEPTH x 64-bit synchronous job FIFO with occupancy count.
module exam_job_fifo
  import exam_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  job_t                       din,
  output job_t                       dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  job_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/exam_job_scheduler.sv
// Queues operand sets and issues them one at a time to the exam core,
// pulsing the core reset between jobs and aborting jobs that overrun.
module exam_job_scheduler
  import exam_sched_pkg::*;
#(
  parameter int              DEPTH   = 4,
  parameter int              TO_W    = 24,
  parameter logic [TO_W-1:0] TIMEOUT = 24'd5_000_000,
  parameter int              TAG_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  exam_job_scheduler_if.slave  job_if,
  output logic                 core_rst,
  output logic                 core_start,
  output logic [OPW-1:0]       core_a,
  output logic [OPW-1:0]       core_b,
  output logic [OPW-1:0]       core_c,
  output logic [OPW-1:0]       core_d,
  input  logic [OPW-1:0]       core_g,
  input  logic [OPW-1:0]       core_h,
  input  logic                 core_done
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] count;
  job_t             push_job;
  job_t             head;
  logic             push;
  logic             pop;
  logic             rdy_en;
  logic             fin_ok;
  logic             fin_to;
  logic [TO_W-1:0]  tmr;
  logic [TAG_W-1:0] tag;
  logic [TAG_W-1:0] job_tag;
  logic [TAG_W-1:0] res_tag_q;
  logic             res_valid_q;
  logic             res_timeout_q;
  logic [OPW-1:0]   res_g_q;
  logic [OPW-1:0]   res_h_q;

  // rdy_en holds off acceptance until the first edge after reset release.
  assign job_if.job_ready = rdy_en && (count < CNT_W'(DEPTH));
  assign push             = job_if.job_valid && job_if.job_ready;
  assign push_job         = {job_if.job_a, job_if.job_b, job_if.job_c, job_if.job_d};

  exam_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_job),
    .dout  (head),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt    = state;
    pop    = 1'b0;
    fin_ok = 1'b0;
    fin_to = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          nxt = LOAD;
        end
      end
      LOAD: nxt = ARM;
      ARM:  nxt = RUN;
      RUN: begin
        // Completion takes priority over an expiring timer on the same cycle.
        if (core_done) begin
          fin_ok = 1'b1;
          nxt    = CAPTURE;
        end else if (tmr == '0) begin
          fin_to = 1'b1;
          nxt    = ABORT;
        end
      end
      CAPTURE: nxt = IDLE;
      ABORT:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Core controls are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en        <= 1'b0;
      core_rst      <= 1'b0;
      core_start    <= 1'b0;
      core_a        <= '0;
      core_b        <= '0;
      core_c        <= '0;
      core_d        <= '0;
      tmr           <= '0;
      tag           <= '0;
      job_tag       <= '0;
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      res_g_q       <= '0;
      res_h_q       <= '0;
      res_tag_q     <= '0;
    end else begin
      rdy_en      <= 1'b1;
      core_rst    <= (nxt == ARM) || (nxt == RUN) || (nxt == CAPTURE) || (nxt == ABORT);
      core_start  <= (nxt == RUN);
      res_valid_q <= fin_ok || fin_to;
      if (pop) begin
        core_a  <= head.a;
        core_b  <= head.b;
        core_c  <= head.c;
        core_d  <= head.d;
        job_tag <= tag;
      end
      // Down-counter: terminal count of zero marks the last allowed RUN cycle.
      if (state == ARM)
        tmr <= TIMEOUT - TO_W'(1);
      else if ((state == RUN) && (tmr != '0))
        tmr <= tmr - TO_W'(1);
      if (fin_ok) begin
        res_g_q       <= core_g;
        res_h_q       <= core_h;
        res_timeout_q <= 1'b0;
      end else if (fin_to) begin
        res_g_q       <= TIMEOUT_VALUE;
        res_h_q       <= TIMEOUT_VALUE;
        res_timeout_q <= 1'b1;
      end
      if (fin_ok || fin_to) begin
        res_tag_q <= job_tag;
        tag       <= tag + TAG_W'(1);
      end
    end
  end

  assign job_if.pending     = count;
  assign job_if.busy        = (state != IDLE);
  assign job_if.res_valid   = res_valid_q;
  assign job_if.res_g       = res_g_q;
  assign job_if.res_h       = res_h_q;
  assign job_if.res_timeout = res_timeout_q;
  assign job_if.res_tag     = res_tag_q;

endmodule

// File: tb/tb_exam_job_scheduler.sv
// Self-checking bench: job-level reference model compared every cycle, plus
// hand-computed expectations for latency, results, timeout, tie and tag wrap.
module tb_exam_job_scheduler;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_rst, core_start, core_done;
  logic [15:0] core_a, core_b, core_c, core_d, core_g, core_h;

  exam_job_scheduler_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) jif ();

  exam_job_scheduler #(
    .DEPTH(DEPTH), .TO_W(24), .TIMEOUT(24'd20), .TAG_W(TAG_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .job_if     (jif),
    .core_rst   (core_rst),
    .core_start (core_start),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_c     (core_c),
    .core_d     (core_d),
    .core_g     (core_g),
    .core_h     (core_h),
    .core_done  (core_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b, c, d;
    int          lat;
  } mjob_t;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: queued jobs plus the one in flight, described by how
  // many cycles have passed since it was taken from the queue.
  mjob_t       mq[$];
  bit          m_act, m_fin, m_ren, m_rv, m_to;
  int          m_phase, m_tag, m_cur_tag, m_cur_lat, m_rtag;
  logic [15:0] m_ca, m_cb, m_cc, m_cd, m_g, m_h;

  int cyc = 0, n_acc = 0, push_cyc = 0, start_cyc = 0, next_lat = 0;
  int sc = 0, run_len = 0, rec_run = 0, prev_rtag = 0, wraps = 0, n_res = 0;
  bit prev_start = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_bound(input string nm, input int budget);
    n_chk++;
    n_err++;
    $display("FAIL %s: event not seen within %0d cycles (cycle %0d)", nm, budget, cyc);
  endtask

  task automatic model_reset();
    mq.delete();
    m_act = 0; m_fin = 0; m_ren = 0; m_rv = 0; m_to = 0;
    m_phase = 0; m_tag = 0; m_cur_tag = 0; m_cur_lat = 0; m_rtag = 0;
    m_ca = '0; m_cb = '0; m_cc = '0; m_cd = '0; m_g = '0; m_h = '0;
  endtask

  task automatic model_step();
    mjob_t j;
    bit rdy, cap, abt;
    if (!rst) begin
      model_reset();
      return;
    end
    rdy  = m_ren && (mq.size() < DEPTH);
    m_rv = 0;
    if (m_fin) begin
      m_fin = 0;
    end else if (m_act) begin
      cap = 0;
      abt = 0;
      if (m_phase >= 3) begin
        if (core_done) cap = 1;
        else if (m_phase - 3 == TIMEOUT - 1) abt = 1;
      end
      if (cap || abt) begin
        m_rv   = 1;
        m_to   = abt;
        m_g    = cap ? core_g : 16'hFFFF;
        m_h    = cap ? core_h : 16'hFFFF;
        m_rtag = m_cur_tag;
        m_tag  = (m_tag + 1) % (1 << TAG_W);
        m_act  = 0;
        m_fin  = 1;
      end else begin
        m_phase++;
      end
    end else if (mq.size() > 0) begin
      j = mq.pop_front();
      m_ca = j.a; m_cb = j.b; m_cc = j.c; m_cd = j.d;
      m_cur_lat = j.lat;
      m_cur_tag = m_tag;
      m_act     = 1;
      m_phase   = 1;
    end
    if (jif.job_valid && rdy) begin
      j.a = jif.job_a; j.b = jif.job_b; j.c = jif.job_c; j.d = jif.job_d;
      j.lat = next_lat;
      mq.push_back(j);
      n_acc++;
      push_cyc = cyc;
    end
    m_ren = 1;
  endtask

  task automatic compare();
    chk("job_ready",   32'(jif.job_ready),   32'(m_ren && (mq.size() < DEPTH)));
    chk("pending",     32'(jif.pending),     32'(mq.size()));
    chk("busy",        32'(jif.busy),        32'(m_act || m_fin));
    chk("core_rst",    32'(core_rst),        32'(m_fin || (m_act && m_phase >= 2)));
    chk("core_start",  32'(core_start),      32'(m_act && m_phase >= 3));
    chk("core_a",      32'(core_a),          32'(m_ca));
    chk("core_b",      32'(core_b),          32'(m_cb));
    chk("core_c",      32'(core_c),          32'(m_cc));
    chk("core_d",      32'(core_d),          32'(m_cd));
    chk("res_valid",   32'(jif.res_valid),   32'(m_rv));
    chk("res_g",       32'(jif.res_g),       32'(m_g));
    chk("res_h",       32'(jif.res_h),       32'(m_h));
    chk("res_timeout", 32'(jif.res_timeout), 32'(m_to));
    chk("res_tag",     32'(jif.res_tag),     32'(m_rtag));
  endtask

  task automatic monitor();
    if (core_start && !prev_start) start_cyc = cyc;
    if (!core_rst) run_len = 0;
    else if (core_start) run_len++;
    if (jif.res_valid) begin
      rec_run = run_len;
      n_res++;
      if (prev_rtag == 15 && jif.res_tag == 4'd0) wraps++;
      prev_rtag = int'(jif.res_tag);
    end
    prev_start = core_start;
  endtask

  // Core stand-in: done rises after cur_lat cycles of start; lat 0 never finishes.
  task automatic core_drive();
    if (!core_rst) begin
      core_done = 1'b0;
      core_g    = '0;
      core_h    = '0;
      sc        = 0;
    end else if (core_start && !core_done) begin
      sc++;
      if (m_cur_lat != 0 && sc >= m_cur_lat) begin
        core_done = 1'b1;
        core_g    = core_a + core_b;
        core_h    = core_c + core_a;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    compare();
    monitor();
    core_drive();
  endtask

  task automatic wait_res(input string nm, input int budget);
    int n0 = n_res;
    for (int i = 0; i < budget; i++) begin
      step();
      if (n_res != n0) return;
    end
    fail_bound(nm, budget);
  endtask

  task automatic drive_job(input logic [15:0] a, b, c, d, input int lat);
    jif.job_valid = 1'b1;
    jif.job_a = a; jif.job_b = b; jif.job_c = c; jif.job_d = d;
    next_lat = lat;
    step();
    jif.job_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, nres0, n0;
    bit drained;
    rst = 1'b0;
    jif.job_valid = 1'b0;
    jif.job_a = '0; jif.job_b = '0; jif.job_c = '0; jif.job_d = '0;
    core_done = 1'b0; core_g = '0; core_h = '0;
    model_reset();

    repeat (3) step();
    chk("rst_core_rst", 32'(core_rst), 32'd0);
    chk("rst_job_ready", 32'(jif.job_ready), 32'd0);
    chk("rst_busy", 32'(jif.busy), 32'd0);
    rst = 1'b1;
    #1;
    chk("ready_before_edge", 32'(jif.job_ready), 32'd0);
    step();
    chk("ready_after_edge", 32'(jif.job_ready), 32'd1);

    // Single job with known operands.
    drive_job(16'd1, 16'd2, 16'd3, 16'd0, 10);
    wait_res("single_res", 60);
    chk("single_start_delay", 32'(start_cyc - push_cyc), 32'd3);
    chk("single_res_g", 32'(jif.res_g), 32'd3);
    chk("single_res_h", 32'(jif.res_h), 32'd4);
    chk("single_tag", 32'(jif.res_tag), 32'd0);
    chk("single_timeout", 32'(jif.res_timeout), 32'd0);
    chk("single_run_len", 32'(rec_run), 32'd10);

    // Burst of six offers while the first job stalls: five fit (one in flight, four queued).
    acc0 = n_acc;
    for (int i = 0; i < 6; i++) begin
      jif.job_valid = 1'b1;
      jif.job_a = 16'($urandom); jif.job_b = 16'($urandom);
      jif.job_c = 16'($urandom); jif.job_d = 16'($urandom);
      next_lat = (i == 0) ? 30 : 5;
      step();
    end
    jif.job_valid = 1'b0;
    chk("burst_accepted", 32'(n_acc - acc0), 32'd5);
    chk("burst_pending", 32'(jif.pending), 32'd4);
    chk("burst_ready", 32'(jif.job_ready), 32'd0);
    for (int t = 1; t <= 5; t++) begin
      wait_res("burst_res", 100);
      chk($sformatf("burst_tag%0d", t), 32'(jif.res_tag), 32'(t));
    end

    // Core never finishes: abort after TIMEOUT RUN cycles, then a normal job.
    drive_job(16'd5, 16'd6, 16'd7, 16'd8, 0);
    wait_res("timeout_res", 100);
    chk("timeout_flag", 32'(jif.res_timeout), 32'd1);
    chk("timeout_g", 32'(jif.res_g), 32'hFFFF);
    chk("timeout_h", 32'(jif.res_h), 32'hFFFF);
    chk("timeout_run_len", 32'(rec_run), 32'd20);
    drive_job(16'd10, 16'd20, 16'd30, 16'd40, 3);
    wait_res("after_timeout_res", 60);
    chk("after_timeout_flag", 32'(jif.res_timeout), 32'd0);
    chk("after_timeout_g", 32'(jif.res_g), 32'd30);
    chk("after_timeout_h", 32'(jif.res_h), 32'd40);

    // Done on the last allowed cycle wins; one cycle later is a timeout.
    drive_job(16'd100, 16'd1, 16'd2, 16'd3, TIMEOUT);
    wait_res("tie_res", 100);
    chk("tie_flag", 32'(jif.res_timeout), 32'd0);
    chk("tie_g", 32'(jif.res_g), 32'd101);
    chk("tie_h", 32'(jif.res_h), 32'd102);
    chk("tie_run_len", 32'(rec_run), 32'd20);
    drive_job(16'd7, 16'd7, 16'd7, 16'd7, TIMEOUT + 1);
    wait_res("late_res", 100);
    chk("late_flag", 32'(jif.res_timeout), 32'd1);

    // Asynchronous reset in the middle of a RUN with jobs still queued.
    drive_job(16'd1, 16'd1, 16'd1, 16'd1, 0);
    drive_job(16'd2, 16'd2, 16'd2, 16'd2, 4);
    drive_job(16'd3, 16'd3, 16'd3, 16'd3, 4);
    repeat (8) step();
    chk("pre_reset_start", 32'(core_start), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_core_rst", 32'(core_rst), 32'd0);
    chk("mid_rst_core_start", 32'(core_start), 32'd0);
    chk("mid_rst_busy", 32'(jif.busy), 32'd0);
    chk("mid_rst_pending", 32'(jif.pending), 32'd0);
    model_reset();
    core_drive();
    nres0 = n_res;
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("release_ready0", 32'(jif.job_ready), 32'd0);
    repeat (6) step();
    chk("release_ready1", 32'(jif.job_ready), 32'd1);
    chk("no_res_after_reset", 32'(n_res - nres0), 32'd0);

    // Random traffic: enough jobs after reset to wrap the tag.
    n0 = n_acc;
    for (int cy = 0; cy < 4000 && (n_acc - n0) < 24; cy++) begin
      jif.job_valid = ($urandom_range(0, 2) == 0);
      jif.job_a = 16'($urandom); jif.job_b = 16'($urandom);
      jif.job_c = 16'($urandom); jif.job_d = 16'($urandom);
      next_lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 22));
      step();
    end
    jif.job_valid = 1'b0;
    if ((n_acc - n0) < 24) fail_bound("random_accept", 4000);
    drained = 0;
    for (int i = 0; i < 3000 && !drained; i++) begin
      step();
      drained = !m_act && !m_fin && (mq.size() == 0);
    end
    if (!drained) fail_bound("random_drain", 3000);
    chk("tag_wrap", 32'(wraps > 0), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
